// File: rtl/maze_rom_arbiter_if.sv
// Bus bundle between the maze ROM arbiter, its two requesters and the ROM macro.
interface maze_rom_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_miss;
    logic              game_req;
    logic [ADDR_W-1:0] game_addr;
    logic              game_gnt;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [15:0]       miss_count;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, game_req, game_addr, rom_dout,
        output disp_rvalid, disp_rdata, disp_miss, game_gnt, game_rvalid,
               game_rdata, rom_en, rom_addr, miss_count
    );

    // Requesters + ROM side
    modport master (
        output disp_req, disp_addr, game_req, game_addr, rom_dout,
        input  disp_rvalid, disp_rdata, disp_miss, game_gnt, game_rvalid,
               game_rdata, rom_en, rom_addr, miss_count
    );
endinterface

// File: rtl/maze_rom_arbiter.sv
// Maze ROM arbiter: display port has fixed priority, the game port is granted
// when display is idle or after STARVE_LIMIT consecutive lost cycles. A tag
// pipeline matching the ROM latency routes returning data to its owner.
module maze_rom_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    maze_rom_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_WAIT = 2'd1, G_BUSY = 2'd2} gstate_e;

    gstate_e            gstate_q, gstate_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ROM_LAT-1:0] tag_own_q, tag_own_d;   // 1 = game owns the slot
    logic [15:0]        miss_cnt_q, miss_cnt_d;

    logic               game_eligible;
    logic               game_wins;
    logic               game_rvalid;
    logic [ADDR_W-1:0]  issue_addr;
    logic [DATA_W-1:0]  rdata;

    // Game FSM state and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gstate_q   <= G_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            gstate_q   <= gstate_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Game FSM next state; a dropped request in G_WAIT is tolerated
    always_comb begin
        gstate_d = gstate_q;
        unique case (gstate_q)
            G_IDLE: if (bus.game_req) gstate_d = game_wins ? G_BUSY : G_WAIT;
            G_WAIT: begin
                if (game_wins)          gstate_d = G_BUSY;
                else if (!bus.game_req) gstate_d = G_IDLE;
            end
            G_BUSY: if (game_rvalid)    gstate_d = G_IDLE;
            default:                    gstate_d = G_IDLE;
        endcase
    end

    // Issue decision: display first, game when display idle or starving
    always_comb begin
        game_eligible = bus.game_req && ((gstate_q == G_IDLE) || (gstate_q == G_WAIT));
        game_wins     = game_eligible && (!bus.disp_req || (wait_cnt_q == STARVE));
        issue_addr    = game_wins ? bus.game_addr : bus.disp_addr;
    end

    // Wait counter counts lost cycles only, capped at the starvation limit
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.game_req || game_wins)
            wait_cnt_d = 4'd0;
        else if (game_eligible && (wait_cnt_q < STARVE))
            wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Tag shift register next state: stage 0 records who issued this cycle
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_own_d = tag_own_q;
        for (int i = ROM_LAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        tag_vld_d[0] = bus.rom_en;
        tag_own_d[0] = game_wins;
    end

    // Tag pipeline register; reset discards in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    // Saturating miss counter next state
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (bus.disp_miss && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    // Miss counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) miss_cnt_q <= 16'd0;
        else     miss_cnt_q <= miss_cnt_d;
    end

    // Output drive: ROM request, grants and routed read data
    always_comb begin
        rdata           = bus.rom_dout;
        game_rvalid     = tag_vld_q[ROM_LAT-1] && tag_own_q[ROM_LAT-1];
        bus.rom_en      = bus.disp_req || game_eligible;
        bus.rom_addr    = issue_addr;
        bus.game_gnt    = game_wins;
        bus.disp_miss   = bus.disp_req && game_wins;
        bus.disp_rvalid = tag_vld_q[ROM_LAT-1] && !tag_own_q[ROM_LAT-1];
        bus.game_rvalid = game_rvalid;
        bus.disp_rdata  = rdata;
        bus.game_rdata  = rdata;
        bus.miss_count  = miss_cnt_q;
    end
endmodule

// File: doc/maze_rom_arbiter.md
Name: maze_rom_arbiter

Overview:
- Shares the single synchronous maze ROM (4096 x 16) between two requesters: the pixel renderer (display port) and the game controller's wall-check read (game port).
- Display has fixed priority. A starvation guard forces a game grant after a bounded wait.
- Read data returns to the owning port after the ROM latency.
- Sits between the maze ROM instance and the renderer/controller.

Parameters:
- ADDR_W, 12, ROM address width ({brow, bcol}).
- DATA_W, 16, ROM data width.
- ROM_LAT, 1, ROM cycles from sampled en/addr to valid dout; legal range 1..4.
- STARVE_LIMIT, 4, consecutive lost cycles after which the game port wins; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- disp_req  in  1  display read request, per cycle, no handshake
- disp_addr  in  ADDR_W  display read address
- disp_rvalid  out  1  display data valid
- disp_rdata  out  DATA_W  display read data
- disp_miss  out  1  pulse: display request denied this cycle
- game_req  in  1  game read request, level, held until game_gnt
- game_addr  in  ADDR_W  game address, stable while game_req is high
- game_gnt  out  1  game request issued to ROM this cycle
- game_rvalid  out  1  game data valid, one-cycle pulse
- game_rdata  out  DATA_W  game read data
- rom_en  out  1  ROM enable
- rom_addr  out  ADDR_W  ROM address
- rom_dout  in  DATA_W  ROM data
- miss_count  out  16  saturating count of disp_miss pulses

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All registered outputs clear to 0: miss_count, tag pipeline, game FSM = G_IDLE, wait counter = 0.
- Combinational issue:
  - rom_en = disp_req | game_eligible.
  - game_eligible = game_req && game FSM in G_IDLE or G_WAIT.
  - game_wins = game_eligible && (!disp_req || wait_cnt == STARVE_LIMIT).
  - rom_addr = game_wins ? game_addr : disp_addr.
  - game_gnt = game_wins.
  - disp_miss = disp_req && game_wins.
  - With no request, rom_addr = disp_addr and rom_en = 0.
- Tag pipeline: ROM_LAT-deep shift register of {valid, owner}. Stage 0 loads {rom_en, game_wins} each cycle.
  - At the pipeline output: disp_rvalid = valid && owner==disp; game_rvalid = valid && owner==game.
  - disp_rdata and game_rdata both equal rom_dout (combinational passthrough) and are meaningful only with their rvalid.
  - Latency: grant/issue in cycle N gives rvalid in cycle N+ROM_LAT.
- Game FSM:
  - G_IDLE: game_req and game_wins -> G_BUSY. game_req and not game_wins -> G_WAIT.
  - G_WAIT: game_wins -> G_BUSY. game_req dropped -> G_IDLE (protocol violation tolerated, wait_cnt cleared).
  - G_BUSY: no new game grant; game_eligible = 0. game_rvalid -> G_IDLE. If game_req is still high on return, it is a new request from the next cycle.
  - At most one game read outstanding.
- wait_cnt (4 bit):
  - Increments each cycle the FSM is in G_IDLE/G_WAIT with game_req high and game_wins = 0.
  - Clears on game_gnt or when game_req is low.
  - Never exceeds STARVE_LIMIT.
- Simultaneous requests: display wins unless wait_cnt == STARVE_LIMIT. The forced game grant lasts exactly one cycle, after which display priority resumes.
- miss_count: +1 per disp_miss; saturates at 16'hFFFF.
- Reset mid-read: the in-flight tag is discarded; no rvalid is produced after reset deassertion for reads issued before reset.

Test Plan:
- Reset, then disp_req=1 with disp_addr=0x041 for 3 cycles, game_req=0 -> rom_en=1 and rom_addr=0x041 each cycle; disp_rvalid=1 one cycle later (ROM_LAT=1) with disp_rdata equal to ROM[0x041]; miss_count=0.
- disp_req=0, game_req=1 with game_addr=0x2A5 -> game_gnt=1 in the same cycle; game_rvalid pulses the next cycle with data = ROM[0x2A5]; FSM returns to G_IDLE; game_req held high gets its next grant 2 cycles after the first.
- disp_req held at 1, game_req=1 with game_addr=0x0C3, STARVE_LIMIT=4 -> 4 cycles with game_gnt=0, then game_gnt=1 on the 5th cycle; disp_miss=1 in that cycle and miss_count=1; display wins again the following cycle.
- ROM_LAT=3, alternating grants disp(0x010), game(0x020), disp(0x030) in cycles 0-2 -> rvalids in cycles 3, 4, 5 on disp, game and disp ports, each with the matching ROM word.
- Assert rst while a game read is in G_BUSY -> after rst deasserts, game_rvalid stays 0, FSM is G_IDLE, miss_count=0, and a new game request is granted normally.
- Force miss_count to 16'hFFFE and generate 3 starvation wins -> miss_count reaches 16'hFFFF and holds.
